// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// Data-memory load/store unit that sits between the CPU datapath and a simple
// req/ack memory bus. A load or store requested by the controller stalls the
// core while one bus transaction runs. The transaction may have any number of
// wait states, and it is aborted after TIMEOUT cycles without an ack. Load
// data is returned on rdata and stays stable while the instruction commits.
//
// Optional feature macro: MEM_SUBWORD_EN
//   When defined, the unit adds mem_size/mem_sext and supports byte, half and
//   word accesses with lane steering and load extension. When undefined, every
//   access is a full word.
//
// Parameters
//   TIMEOUT  : maximum BUSY cycles spent waiting for bus_ack before abort (>=1)
//   CNT_W    : width of the wait counter (must be able to hold TIMEOUT)
//
// Ports
//   clk        in   1   system clock, rising edge
//   rst        in   1   asynchronous active-low reset
//   mem_rd     in   1   load request (level, held for the whole instruction)
//   mem_wr     in   1   store request (level)
//   addr       in   32  byte address
//   wdata      in   32  store data
//   mem_size   in   2   (MEM_SUBWORD_EN) 00 byte, 01 half, 10 word
//   mem_sext   in   1   (MEM_SUBWORD_EN) 1 = sign-extend loads
//   rdata      out  32  load data to the datapath
//   stall      out  1   1 = instruction must not commit this cycle (combinational)
//   err        out  1   one-cycle pulse: misaligned, rd&wr conflict, or timeout
//   bus_req    out  1   bus request, held until bus_ack or timeout
//   bus_we     out  1   1 = write transaction
//   bus_addr   out  32  word-aligned address
//   bus_wdata  out  32  lane-positioned write data
//   bus_be     out  4   byte enables, bit i = byte lane i
//   bus_ack    in   1   slave completion strobe
//   bus_rdata  in   32  read data, valid with bus_ack
// -----------------------------------------------------------------------------
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
`ifdef MEM_SUBWORD_EN
    input  logic [1:0]  mem_size,
    input  logic        mem_sext,
`endif
    output logic [31:0] rdata,
    output logic        stall,
    output logic        err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [31:0] r_rdata, w_rdata_nxt;
    logic        r_err, w_err_nxt;
    logic        r_bus_req, w_bus_req_nxt;
    logic        r_bus_we, w_bus_we_nxt;
    logic [31:0] r_bus_addr, w_bus_addr_nxt;
    logic [31:0] r_bus_wdata, w_bus_wdata_nxt;
    logic [3:0]  r_bus_be, w_bus_be_nxt;

    logic        w_req;
    logic        w_misalign;
    logic [3:0]  w_be;
    logic [31:0] w_wdata_lane;
    logic [31:0] w_load;

`ifdef MEM_SUBWORD_EN
    logic [1:0]  r_size, w_size_nxt;
    logic        r_sext, w_sext_nxt;
    logic [1:0]  r_lane, w_lane_nxt;

    // Move the addressed lane down to bit 0 and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(input logic [31:0] d,
                                             input logic [1:0]  lane,
                                             input logic [1:0]  size,
                                             input logic        sext);
        logic [31:0] sh;
        sh = d >> {lane, 3'b000};
        case (size)
            2'b00:   fmt_load = {{24{sext & sh[7]}}, sh[7:0]};
            2'b01:   fmt_load = {{16{sext & sh[15]}}, sh[15:0]};
            default: fmt_load = d;
        endcase
    endfunction

    // Decode alignment, byte enables and store lane replication from the request.
    always_comb begin
        w_misalign   = 1'b0;
        w_be         = 4'hF;
        w_wdata_lane = wdata;
        case (mem_size)
            2'b00: begin
                w_misalign   = 1'b0;
                w_be         = 4'b0001 << addr[1:0];
                w_wdata_lane = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_misalign   = addr[0];
                w_be         = 4'b0011 << {addr[1], 1'b0};
                w_wdata_lane = {2{wdata[15:0]}};
            end
            default: begin
                w_misalign   = (addr[1:0] != 2'b00);
                w_be         = 4'hF;
                w_wdata_lane = wdata;
            end
        endcase
    end

    assign w_load = fmt_load(bus_rdata, r_lane, r_size, r_sext);
`else
    assign w_misalign   = (addr[1:0] != 2'b00);
    assign w_be         = 4'hF;
    assign w_wdata_lane = wdata;
    assign w_load       = bus_rdata;
`endif

    assign w_req = mem_rd | mem_wr;

    // Stall while a request waits in IDLE or a transaction is in flight; forced low in reset.
    assign stall = rst & (((r_state == S_IDLE) & w_req) | (r_state == S_BUSY));

    // Next-state and next-register values for the access sequencer.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_rdata_nxt     = r_rdata;
        w_err_nxt       = 1'b0;
        w_bus_req_nxt   = r_bus_req;
        w_bus_we_nxt    = r_bus_we;
        w_bus_addr_nxt  = r_bus_addr;
        w_bus_wdata_nxt = r_bus_wdata;
        w_bus_be_nxt    = r_bus_be;
`ifdef MEM_SUBWORD_EN
        w_size_nxt      = r_size;
        w_sext_nxt      = r_sext;
        w_lane_nxt      = r_lane;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_misalign) begin
                        // No bus traffic for a misaligned access; fail it straight away.
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = 32'h0000_0000;
                        w_state_nxt = S_DONE;
                    end else begin
                        // A simultaneous rd and wr is run as a write but still flagged.
                        w_err_nxt       = mem_rd & mem_wr;
                        w_bus_req_nxt   = 1'b1;
                        w_bus_we_nxt    = mem_wr;
                        w_bus_addr_nxt  = {addr[31:2], 2'b00};
                        w_bus_wdata_nxt = w_wdata_lane;
                        w_bus_be_nxt    = w_be;
                        w_cnt_nxt       = {CNT_W{1'b0}};
`ifdef MEM_SUBWORD_EN
                        w_size_nxt      = mem_size;
                        w_sext_nxt      = mem_sext;
                        w_lane_nxt      = addr[1:0];
`endif
                        w_state_nxt     = S_BUSY;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus_ack) begin
                    // An ack always wins, including on the final allowed cycle.
                    w_bus_req_nxt = 1'b0;
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    if (!r_bus_we) begin
                        w_rdata_nxt = w_load;
                    end else begin
                        w_rdata_nxt = r_rdata;
                    end
                    w_state_nxt   = S_DONE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_bus_req_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_rdata_nxt   = 32'h0000_0000;
                    w_cnt_nxt     = {CNT_W{1'b0}};
                    w_state_nxt   = S_DONE;
                end else begin
                    w_cnt_nxt     = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt   = S_IDLE;
                w_bus_req_nxt = 1'b0;
                w_cnt_nxt     = {CNT_W{1'b0}};
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_rdata     <= 32'h0000_0000;
            r_err       <= 1'b0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'h0000_0000;
            r_bus_wdata <= 32'h0000_0000;
            r_bus_be    <= 4'h0;
`ifdef MEM_SUBWORD_EN
            r_size      <= 2'b10;
            r_sext      <= 1'b0;
            r_lane      <= 2'b00;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rdata     <= w_rdata_nxt;
            r_err       <= w_err_nxt;
            r_bus_req   <= w_bus_req_nxt;
            r_bus_we    <= w_bus_we_nxt;
            r_bus_addr  <= w_bus_addr_nxt;
            r_bus_wdata <= w_bus_wdata_nxt;
            r_bus_be    <= w_bus_be_nxt;
`ifdef MEM_SUBWORD_EN
            r_size      <= w_size_nxt;
            r_sext      <= w_sext_nxt;
            r_lane      <= w_lane_nxt;
`endif
        end
    end

    assign rdata     = r_rdata;
    assign err       = r_err;
    assign bus_req   = r_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign bus_be    = r_bus_be;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Directed and randomized load/store accesses against mem_access_unit. The
// bench acts as the bus slave and predicts every output from the access
// rules (alignment, byte lanes, wait states, timeout, extension).
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd, mem_wr;
    logic [31:0] addr, wdata;
`ifdef MEM_SUBWORD_EN
    logic [1:0]  mem_size;
    logic        mem_sext;
`endif
    logic [31:0] rdata;
    logic        stall, err, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] m_rdata    = 32'h0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .addr      (addr),
        .wdata     (wdata),
`ifdef MEM_SUBWORD_EN
        .mem_size  (mem_size),
        .mem_sext  (mem_sext),
`endif
        .rdata     (rdata),
        .stall     (stall),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_be    (bus_be),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("%s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete instruction: request, wait states / timeout, commit, idle.
    // ack_at = BUSY cycle (1-based) carrying the ack; outside 1..TO means no ack.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sx,
                          input int ack_at, input logic [31:0] rdv);
        logic        mis, tout;
        logic [3:0]  ebe;
        logic [31:0] ewd, eld;
        int          nb;
`ifdef MEM_SUBWORD_EN
        int          lane;
        lane = int'(a % 32'd4);
        if (sz == 2'd0) begin
            mis = 1'b0;
            ebe = 4'(1 << lane);
            ewd = {24'h0, wd[7:0]} * 32'h0101_0101;
            eld = (rdv >> (8 * lane)) & 32'hFF;
            if (sx && eld >= 32'h80) eld = eld + 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            mis = (lane % 2) != 0;
            ebe = 4'(3 << (lane / 2 * 2));
            ewd = {16'h0, wd[15:0]} * 32'h0001_0001;
            eld = (rdv >> (16 * (lane / 2))) & 32'hFFFF;
            if (sx && eld >= 32'h8000) eld = eld + 32'hFFFF_0000;
        end else begin
            mis = lane != 0;
            ebe = 4'hF;
            ewd = wd;
            eld = rdv;
        end
`else
        mis = (a % 32'd4) != 32'd0;
        ebe = 4'hF;
        ewd = wd;
        eld = rdv;
        if (sz != 2'd2 || sx) $display("note: size/sext ignored in word-only build");
`endif
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = wd;
`ifdef MEM_SUBWORD_EN
        mem_size = sz; mem_sext = sx;
`endif
        bus_ack = 1'($urandom_range(0, 1));   // ack while IDLE must be ignored
        bus_rdata = $urandom;
        #1;
        chk("req_cycle_stall", stall, 1);
        chk("req_cycle_bus_req", bus_req, 0);
        if (mis) begin
            @(negedge clk);
            bus_ack = 1'b0;
            m_rdata = 32'h0;
            chk("misalign_err", err, 1);
            chk("misalign_rdata", rdata, m_rdata);
            chk("misalign_stall", stall, 0);
            chk("misalign_bus_req", bus_req, 0);
        end else begin
            tout = !(ack_at >= 1 && ack_at <= TO);
            nb   = tout ? TO : ack_at;
            for (int k = 1; k <= nb; k++) begin
                @(negedge clk);
                chk("busy_bus_req", bus_req, 1);
                chk("busy_stall", stall, 1);
                chk("busy_err", err, (k == 1 && rd && wr) ? 1 : 0);
                chk("busy_bus_we", bus_we, wr);
                chk("busy_bus_addr", bus_addr, a & 32'hFFFF_FFFC);
                chk("busy_bus_be", bus_be, ebe);
                if (wr) chk("busy_bus_wdata", bus_wdata, ewd);
                bus_ack   = (k == ack_at);
                bus_rdata = (k == ack_at) ? rdv : $urandom;
            end
            @(negedge clk);
            bus_ack = 1'b0;
            if (tout) m_rdata = 32'h0;
            else if (!wr) m_rdata = eld;
            chk("done_err", err, tout);
            chk("done_stall", stall, 0);
            chk("done_bus_req", bus_req, 0);
            chk("done_rdata", rdata, m_rdata);
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        @(negedge clk);
        chk("after_err", err, 0);
        chk("after_stall", stall, 0);
        chk("after_bus_req", bus_req, 0);
        chk("after_rdata", rdata, m_rdata);
        bus_ack = 1'b0;
    endtask

    initial begin
        logic        rd, wr;
        logic [31:0] a;
        logic [1:0]  sz;
        int          ack_at;

        rst = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0; addr = 32'h0; wdata = 32'h0;
`ifdef MEM_SUBWORD_EN
        mem_size = 2'd2; mem_sext = 1'b0;
`endif
        bus_ack = 1'b0; bus_rdata = 32'h0;
        repeat (2) @(negedge clk);
        chk("reset_rdata", rdata, 0);
        chk("reset_err", err, 0);
        chk("reset_bus_req", bus_req, 0);
        chk("reset_bus_we", bus_we, 0);
        chk("reset_bus_addr", bus_addr, 0);
        chk("reset_bus_wdata", bus_wdata, 0);
        chk("reset_bus_be", bus_be, 0);
        chk("reset_stall", stall, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_stall", stall, 0);

        // Load with two BUSY cycles, then store with immediate ack.
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2'd2, 1'b0, 2, 32'h1234_5678);
        access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 2'd2, 1'b0, 1, 32'h5555_AAAA);

        // Reset in the middle of BUSY drops everything at once.
        @(negedge clk);
        mem_rd = 1'b1; addr = 32'h0000_0040;
        @(negedge clk);
        chk("rst_pre_bus_req", bus_req, 1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_rdata = 32'h0;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_rdata", rdata, m_rdata);
        @(negedge clk);
        mem_rd = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", stall, 0);
        chk("post_rst_bus_req", bus_req, 0);

        // Misaligned word load, timeout, recovery, ack on the final cycle, conflict.
        access(1'b1, 1'b0, 32'h0000_0050, 32'h0, 2'd2, 1'b0, 1, 32'h7777_0001);
        access(1'b1, 1'b0, 32'h0000_0022, 32'h0, 2'd2, 1'b0, 1, 32'h1111_1111);
        access(1'b1, 1'b0, 32'h0000_0030, 32'h0, 2'd2, 1'b0, 0, 32'h2222_2222);
        access(1'b1, 1'b0, 32'h0000_0034, 32'h0, 2'd2, 1'b0, 1, 32'h0BAD_BEEF);
        access(1'b1, 1'b0, 32'h0000_0038, 32'h0, 2'd2, 1'b0, TO, 32'hFEED_0042);
        access(1'b1, 1'b1, 32'h0000_0044, 32'h0102_0304, 2'd2, 1'b0, 3, 32'h3333_3333);

`ifdef MEM_SUBWORD_EN
        access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 2'd0, 1'b1, 1, 32'h80AB_CDEF);
        access(1'b0, 1'b1, 32'h0000_0011, 32'h0000_00AB, 2'd0, 1'b0, 1, 32'h0);
        access(1'b1, 1'b0, 32'h0000_0016, 32'h0, 2'd1, 1'b1, 2, 32'h9234_5678);
        access(1'b1, 1'b0, 32'h0000_0015, 32'h0, 2'd1, 1'b0, 1, 32'h4444_4444);
`endif

        // Randomized accesses.
        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd ? ($urandom_range(0, 7) == 0) : 1'b1;
            a  = $urandom;
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            ack_at = ($urandom_range(0, 9) == 0) ? TO + 4 : int'($urandom_range(1, 6));
`ifdef MEM_SUBWORD_EN
            sz = 2'($urandom_range(0, 2));
`else
            sz = 2'd2;
`endif
            access(rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)), ack_at, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
